// File: rtl/if_id_queue_pkg.sv
// Shared pipeline constants and types used between the fetch and decode stages.
package if_id_queue_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRY_W = 96;

  // addi x0,x0,0 -- shown to decode whenever no instruction is available
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: small circular FIFO between fetch and decode.
// Full/valid are decoded from the registered count only, so there is no
// combinational path from StallD to StallF.
module if_id_queue #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = if_id_queue_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ValidF,
  input  logic [31:0]              InstrF,
  input  logic [31:0]              PCF,
  input  logic [31:0]              PCPlus4F,
  input  logic                     FlushD,
  input  logic                     StallD,
  output logic                     StallF,
  output logic                     ValidD,
  output logic [31:0]              InstrD,
  output logic [31:0]              PCD,
  output logic [31:0]              PCPlus4D,
  output logic [$clog2(DEPTH):0]   CountQ
);

  import if_id_queue_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0 ||
      $bits(if_id_entry_t) != ENTRY_W) begin : g_bad_cfg
    $error("if_id_queue: DEPTH must be 2, 4 or 8");
  end

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  if_id_entry_t  mem [DEPTH];
  if_id_entry_t  wr_entry;
  if_id_entry_t  head;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign push   = ValidF & ~full & ~FlushD;
  assign pop    = ~empty & ~StallD & ~FlushD;

  assign StallF = full;
  assign ValidD = ~empty;
  assign CountQ = count;

  assign wr_entry = '{instr: InstrF, pc: PCF, pc_plus4: PCPlus4F};

  // Pointer and occupancy tracking; flush wins over any push/pop that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (FlushD) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // Head presentation, substituting a NOP with zero PCs while empty.
  always_comb begin
    head     = mem[rd_ptr];
    InstrD   = head.instr;
    PCD      = head.pc;
    PCPlus4D = head.pc_plus4;
    if (empty) begin
      InstrD   = NOP_INSTR;
      PCD      = '0;
      PCPlus4D = '0;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios followed by random
// traffic, checked through a scoreboard of accepted fetch entries.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst;
  logic          ValidF;
  logic [31:0]   InstrF;
  logic [31:0]   PCF;
  logic [31:0]   PCPlus4F;
  logic          FlushD;
  logic          StallD;
  logic          StallF;
  logic          ValidD;
  logic [31:0]   InstrD;
  logic [31:0]   PCD;
  logic [31:0]   PCPlus4D;
  logic [CW-1:0] CountQ;

  if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .ValidF(ValidF), .InstrF(InstrF), .PCF(PCF),
    .PCPlus4F(PCPlus4F), .FlushD(FlushD), .StallD(StallD), .StallF(StallF),
    .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .CountQ(CountQ)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [95:0] sb_q[$];
  int unsigned mcount  = 0;   // occupancy the reference queue will have after the next edge
  int unsigned exp_now = 0;   // occupancy expected during the current cycle
  logic [31:0] pc      = '0;

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: mid-cycle status checks, and scoreboard compare on every handoff.
  always @(negedge clk) begin : mon
    logic [95:0] e;
    chk("count", 96'(CountQ), 96'(exp_now));
    chk("stallf", 96'(StallF), 96'(exp_now == DEPTH));
    chk("validd", 96'(ValidD), 96'(exp_now != 0));
    if (exp_now == 0) chk("empty_outputs", {InstrD, PCD, PCPlus4D}, {NOP, 64'h0});
    if (ValidD && !StallD && !FlushD) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL handoff_underflow got=pc %h exp=no entry", PCD);
      end else begin
        e = sb_q.pop_front();
        chk("head_entry", {InstrD, PCD, PCPlus4D}, e);
      end
    end
  end

  // Drive one cycle of inputs and record what the queue must do at the next edge.
  task automatic step(input logic vf, input logic stall, input logic fl);
    bit acc;
    bit dec;
    ValidF   = vf;
    StallD   = stall;
    FlushD   = fl;
    InstrF   = $urandom;
    PCF      = pc;
    PCPlus4F = pc + 32'd4;
    exp_now  = mcount;
    if (fl) begin
      sb_q.delete();
      mcount = 0;
    end else begin
      acc = vf && (mcount < DEPTH);
      dec = (mcount > 0) && !stall;
      if (acc) begin
        sb_q.push_back({InstrF, PCF, PCPlus4F});
        pc = pc + 32'd4;
      end
      mcount = mcount + (acc ? 1 : 0) - (dec ? 1 : 0);
    end
    @(posedge clk);
    #2;
  endtask

  // Drop reset between edges and check outputs settle before the next edge.
  task automatic async_reset();
    ValidF = 1'b0;
    StallD = 1'b1;
    FlushD = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_count", 96'(CountQ), 96'(0));
    chk("rst_stallf", 96'(StallF), 96'(0));
    chk("rst_validd", 96'(ValidD), 96'(0));
    chk("rst_outputs", {InstrD, PCD, PCPlus4D}, {NOP, 64'h0});
    sb_q.delete();
    mcount  = 0;
    exp_now = 0;
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    ValidF   = 1'b0;
    InstrF   = '0;
    PCF      = '0;
    PCPlus4F = '0;
    FlushD   = 1'b0;
    StallD   = 1'b0;
    #1;
    chk("por_count", 96'(CountQ), 96'(0));
    chk("por_outputs", {InstrD, PCD, PCPlus4D}, {NOP, 64'h0});
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // fill while decode stalls: third offer refused
    repeat (3) step(1'b1, 1'b1, 1'b0);
    // drain with nothing offered
    repeat (3) step(1'b0, 1'b0, 1'b0);
    // streaming
    repeat (8) step(1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    // flush with a full queue and a pending offer
    repeat (2) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    // wrap with alternating stall
    for (int i = 0; i < 10; i++) step(1'b1, 1'(i % 2), 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    // asynchronous reset while full, then first push after reset
    repeat (2) step(1'b1, 1'b1, 1'b0);
    async_reset();
    repeat (2) step(1'b1, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 15) == 0);
    end

    repeat (DEPTH + 1) step(1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", 96'(sb_q.size()), 96'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning entry count; only powers of two from 2 to 8 are legal.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, meaning the instruction presented when the queue is empty (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ValidF  input  1  fetch stage offers a valid instruction this cycle.
REQ-006 SHALL have port InstrF, PCF, PCPlus4F  input  32 each  fetched instruction, its PC, and PC+4.
REQ-007 SHALL have port FlushD  input  1  redirect (taken branch/jump in execute) discards all queued entries.
REQ-008 SHALL have port StallD  input  1  decode cannot accept the head entry this cycle.
REQ-009 SHALL have port StallF  output  1  queue full; fetch holds its PC.
REQ-010 SHALL have port ValidD  output  1  head entry is valid.
REQ-011 SHALL have port InstrD, PCD, PCPlus4D  output  32 each  head entry fields.
REQ-012 SHALL have port CountQ  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-013 SHALL implement a circular FIFO of DEPTH entries, each entry {Instr, PC, PCPlus4} = 96 bits.
REQ-014 SHALL define push = ValidF & ~StallF & ~FlushD, and pop = ValidD & ~StallD & ~FlushD.
REQ-015 SHALL drive StallF = (CountQ == DEPTH), decoded from registered count only, with no combinational path from StallD.
REQ-016 SHALL refuse a push when full even if a pop occurs in the same cycle; fetch retries next cycle.
REQ-017 SHALL drive ValidD = (CountQ != 0), with InstrD/PCD/PCPlus4D taken combinationally from the head entry.
REQ-018 SHALL drive InstrD = NOP_INSTR, PCD = 0, and PCPlus4D = 0 when empty.
REQ-019 SHALL have latency of exactly one cycle: an entry pushed at edge N is visible on the outputs after edge N.
REQ-020 SHALL handle simultaneous push and pop (count between 1 and DEPTH-1) by advancing both pointers and leaving the count unchanged.
REQ-021 SHALL, when empty, make a pushed entry appear after the edge; there is no same-cycle bypass.
REQ-022 SHALL let pointers wrap modulo DEPTH and keep the count within 0..DEPTH at all times.
REQ-023 SHALL, on FlushD high, zero the count and both pointers at the next edge, ignore push and pop that cycle, and leave entry storage as don't-care.
REQ-024 SHALL give FlushD priority over StallD and ValidF.
REQ-025 SHALL preserve head entry outputs unchanged while StallD is held high.

Reset
REQ-026 SHALL, while rst is low, force count = 0, read pointer = 0, and write pointer = 0 asynchronously, independent of clk.
REQ-027 SHALL produce these outputs during and after reset: StallF=0, ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, CountQ=0.
REQ-028 SHALL not require entry storage to be reset.
REQ-029 SHALL, on reset assertion mid-operation, discard all entries; the first push after deassertion is the first entry output.

Structure
REQ-030 SHALL place NOP_INSTR and the entry width constant (96) in the shared pipeline package, alongside the other stage constants.
REQ-031 SHALL be a single module with no sub-modules; storage SHALL be a register array, not an instantiated memory.

Verification
REQ-032 Fill: rst low then high; ValidF=1 with PCF=0,4,8 and StallD=1 for 3 cycles -> CountQ=2, StallF=1, PCD=0, InstrD unchanged; third offer not taken.
REQ-033 Drain: from full, StallD=0 with ValidF=0 -> PCD=0, then 4, then ValidD=0 with InstrD=32'h00000013; CountQ goes 2,1,0.
REQ-034 Streaming: ValidF=1 and StallD=0 continuously, PCF incrementing by 4 -> ValidD one cycle after the first push, with one entry per cycle in order and CountQ steady at 1.
REQ-035 Flush: CountQ=2 plus a pending ValidF=1 and FlushD=1 for one cycle -> next cycle CountQ=0, ValidD=0, StallF=0, and the pending entry is not stored.
REQ-036 Wrap: 10 push/pop cycles at DEPTH=2 with alternating stall -> output PC sequence matches input PC sequence with no duplication or loss.
REQ-037 Async reset: drop rst between clock edges with CountQ=2 -> outputs reach their reset values before the next edge.
